// File: rtl/echo_delay_proc.sv
// Echo processor: mixes each sample with a half-amplitude copy of the sample
// taken cur_delay samples earlier. cur_delay ramps by 1 per sample toward sw*STEP.
module echo_delay_proc #(
    parameter int AW   = 13,
    parameter int STEP = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [9:0]  data_in,
    input  logic        data_valid,
    input  logic [8:0]  sw,
    output logic [9:0]  data_out,
    output logic        out_valid,
    output logic [19:0] delay,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   cur_delay;
    logic [AW-1:0]   filled;
    logic [9:0]      x;

    logic [9:0]      mem [2**AW];
    logic [9:0]      ram_q;
    logic [AW-1:0]   ram_addr;

    // Single-port sample buffer: written in WR, read address held otherwise.
    assign ram_addr = (state == WR) ? wr_ptr : rd_addr;

    always_ff @(posedge sysclk) begin
        if (state == WR)
            mem[ram_addr] <= x;
        ram_q <= mem[ram_addr];
    end

    logic                echo_en;
    logic [9:0]          echo;
    logic signed [10:0]  sum;
    logic [9:0]          sat;
    logic [AW:0]         target;
    logic [AW-1:0]       next_delay;

    // Only use the buffer once enough history has been written to avoid stale data.
    assign echo_en = (cur_delay != '0) && (cur_delay <= filled);
    assign echo    = echo_en ? ram_q : 10'd0;
    assign sum     = $signed({x[9], x}) + ($signed({echo[9], echo}) >>> 1);
    assign target  = (AW+1)'(sw) * (AW+1)'(STEP);

    always_comb begin
        sat = sum[9:0];
        if (sum[10] != sum[9])
            sat = sum[10] ? 10'h200 : 10'h1FF;
    end

    always_comb begin
        next_delay = cur_delay;
        if (target > {1'b0, cur_delay})
            next_delay = cur_delay + 1'b1;
        else if (target < {1'b0, cur_delay})
            next_delay = cur_delay - 1'b1;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_addr   <= '0;
            filled    <= '0;
            cur_delay <= '0;
            x         <= '0;
            data_out  <= 10'd512;
            out_valid <= 1'b0;
            delay     <= '0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        // Offset binary to two's complement: flip the MSB.
                        x       <= {~data_in[9], data_in[8:0]};
                        rd_addr <= wr_ptr - cur_delay;
                        busy    <= 1'b1;
                        state   <= RD;
                    end
                end
                RD: state <= CALC;
                CALC: begin
                    data_out  <= {~sat[9], sat[8:0]};
                    out_valid <= 1'b1;
                    state     <= WR;
                end
                WR: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (filled != {AW{1'b1}})
                        filled <= filled + 1'b1;
                    cur_delay <= next_delay;
                    delay     <= {{(20-AW){1'b0}}, next_delay};
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
